// File: rtl/tiles_pkg.sv
// Shared definitions for the tile scroll/column-copy sequencer: register map,
// FSM states and status bit positions.
package tiles_pkg;

    localparam int ROWS_DEF        = 16;
    localparam int COL_BITS_DEF    = 6;
    localparam int OFFSET_BITS_DEF = 10;

    localparam logic [4:0] REG_STAGE_LAST = 5'd15;
    localparam logic [4:0] REG_COMMIT     = 5'd16;
    localparam logic [4:0] REG_SPEED      = 5'd17;
    localparam logic [4:0] REG_OFFSET     = 5'd18;
    localparam logic [4:0] REG_STATUS     = 5'd19;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_REJECT   = 1;
    localparam int STAT_OVERFLOW = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COPY
    } state_t;

endpackage

// File: rtl/tile_scroll_ctrl_staging_ram.sv
// Column staging register file: one write port, a CPU read port and a copy
// read port, both combinational.
module staging_ram
    import tiles_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int DW   = 8,
    parameter int AW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem_q [ROWS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/tile_scroll_ctrl.sv
// Stages one tile column from the CPU and copies it into the tilemap at the
// next vertical blank, while advancing the fine scroll offset once per frame.
module tile_scroll_ctrl
    import tiles_pkg::*;
#(
    parameter int ROWS        = ROWS_DEF,
    parameter int COL_BITS    = COL_BITS_DEF,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   chipselect,
    input  logic                   write,
    input  logic [4:0]             address,
    input  logic [15:0]            writedata,
    output logic [15:0]            readdata,
    input  logic                   vblank_start,
    output logic [13:0]            tm_address,
    output logic                   tm_we,
    output logic [7:0]             tm_din,
    output logic [OFFSET_BITS-1:0] scroll_offset,
    output logic                   busy
);

    localparam int RB = $clog2(ROWS);

    state_t                 state_q, state_d;
    logic [RB-1:0]          row_q, row_d;
    logic [COL_BITS-1:0]    col_q, col_d;
    logic [OFFSET_BITS-1:0] speed_q, speed_d;
    logic [OFFSET_BITS-1:0] offset_q, offset_d;
    logic                   reject_q, reject_d;
    logic                   overflow_q, overflow_d;
    logic                   tm_we_q, tm_we_d;
    logic [13:0]            tm_addr_q, tm_addr_d;
    logic [7:0]             tm_din_q, tm_din_d;

    logic                   reg_wr;
    logic                   busy_c;
    logic                   copy_step;
    logic                   stg_we;
    logic [7:0]             stg_rdata_cpu;
    logic [7:0]             stg_rdata_copy;
    logic                   unused_wd;

    assign unused_wd = ^writedata[15:OFFSET_BITS];
    assign reg_wr    = chipselect & write;
    assign busy_c    = (state_q != IDLE);

    staging_ram #(
        .ROWS (ROWS),
        .DW   (8),
        .AW   (RB)
    ) u_staging (
        .clk       (clk),
        .reset     (reset),
        .we_i      (stg_we),
        .waddr_i   (address[RB-1:0]),
        .wdata_i   (writedata[7:0]),
        .raddr_a_i (address[RB-1:0]),
        .rdata_a_o (stg_rdata_cpu),
        .raddr_b_i (row_q),
        .rdata_b_o (stg_rdata_copy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            speed_q    <= '0;
            offset_q   <= '0;
            reject_q   <= 1'b0;
            overflow_q <= 1'b0;
            tm_we_q    <= 1'b0;
            tm_addr_q  <= '0;
            tm_din_q   <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            speed_q    <= speed_d;
            offset_q   <= offset_d;
            reject_q   <= reject_d;
            overflow_q <= overflow_d;
            tm_we_q    <= tm_we_d;
            tm_addr_q  <= tm_addr_d;
            tm_din_q   <= tm_din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        speed_d    = speed_q;
        offset_d   = offset_q;
        reject_d   = reject_q;
        overflow_d = overflow_q;
        tm_we_d    = 1'b0;
        tm_addr_d  = tm_addr_q;
        tm_din_d   = tm_din_q;
        stg_we     = 1'b0;
        copy_step  = 1'b0;

        // Staging and commit are frozen while a column is pending or copying.
        if (reg_wr) begin
            if (address <= REG_STAGE_LAST) begin
                if (busy_c) reject_d = 1'b1;
                else        stg_we   = 1'b1;
            end else if (address == REG_COMMIT) begin
                if (busy_c) begin
                    overflow_d = 1'b1;
                end else begin
                    col_d   = writedata[COL_BITS-1:0];
                    state_d = ARMED;
                end
            end else if (address == REG_SPEED) begin
                speed_d = writedata[OFFSET_BITS-1:0];
            end else if (address == REG_STATUS) begin
                if (writedata[STAT_REJECT])   reject_d   = 1'b0;
                if (writedata[STAT_OVERFLOW]) overflow_d = 1'b0;
            end
        end

        if (reg_wr && address == REG_OFFSET) begin
            offset_d = writedata[OFFSET_BITS-1:0];
        end else if (vblank_start) begin
            offset_d = offset_q + speed_q;
        end

        case (state_q)
            IDLE:    ;
            ARMED:   copy_step = vblank_start;
            COPY:    copy_step = 1'b1;
            default: state_d = IDLE;
        endcase

        // row_q is 0 on entry from ARMED, so the first tile is issued on the vblank edge itself.
        if (copy_step) begin
            tm_we_d   = 1'b1;
            tm_addr_d = 14'({row_q, col_q});
            tm_din_d  = stg_rdata_copy;
            row_d     = row_q + 1'b1;
            state_d   = (row_q == RB'(ROWS - 1)) ? IDLE : COPY;
        end
    end

    always_comb begin
        readdata = '0;
        if (address <= REG_STAGE_LAST) begin
            readdata = 16'(stg_rdata_cpu);
        end else if (address == REG_SPEED) begin
            readdata = 16'(speed_q);
        end else if (address == REG_OFFSET) begin
            readdata = 16'(offset_q);
        end else if (address == REG_STATUS) begin
            readdata = 16'({overflow_q, reject_q, busy_c});
        end
    end

    assign tm_we         = tm_we_q;
    assign tm_address    = tm_addr_q;
    assign tm_din        = tm_din_q;
    assign scroll_offset = offset_q;
    assign busy          = busy_c;

endmodule

// File: tb/tb_tile_scroll_ctrl.sv
// Directed bench for tile_scroll_ctrl: tilemap writes are checked by a
// scoreboard monitor, register/offset values by direct comparisons.
module tb_tile_scroll_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  address = '0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        vblank_start = 1'b0;
    logic [13:0] tm_address;
    logic        tm_we;
    logic [7:0]  tm_din;
    logic [9:0]  scroll_offset;
    logic        busy;

    typedef struct packed {
        logic [13:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        sb_q[$];
    wr_t        mon_e;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] stg[16];

    tile_scroll_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .chipselect    (chipselect),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .vblank_start  (vblank_start),
        .tm_address    (tm_address),
        .tm_we         (tm_we),
        .tm_din        (tm_din),
        .scroll_offset (scroll_offset),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!reset && tm_we) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h din=%h, none expected", tm_address, tm_din);
            end else begin
                mon_e = sb_q.pop_front();
                if ({tm_address, tm_din} !== {mon_e.a, mon_e.d}) begin
                    errors++;
                    $display("FAIL tm_write: got addr=%h din=%h, expected addr=%h din=%h",
                             tm_address, tm_din, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [15:0] exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic vb();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
    endtask

    task automatic stage(input int r, input logic [7:0] v);
        wr(5'(r), 16'(v));
        stg[r] = v;
    endtask

    task automatic push_col(input logic [5:0] col);
        wr_t e;
        for (int r = 0; r < 16; r++) begin
            e.a = 14'({4'(r), col});
            e.d = stg[r];
            sb_q.push_back(e);
        end
    endtask

    task automatic copy(input logic [5:0] col, input bit mid_vb);
        push_col(col);
        vb();
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k < 16) begin
                chk("copy_we", tm_we, 1);
            end else begin
                chk("copy_end_we", tm_we, 0);
                chk("copy_end_busy", busy, 0);
            end
            tick();
            vblank_start = mid_vb && (k == 4);
        end
        vblank_start = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 16; r++) stg[r] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        rd("rst_speed", 5'd17, 16'h0);
        rd("rst_offset", 5'd18, 16'h0);
        rd("rst_status", 5'd19, 16'h0);
        chk("rst_tm_we", tm_we, 0);
        chk("rst_scroll", scroll_offset, 0);

        for (int r = 0; r < 16; r++) stage(r, 8'(8'h10 + r));
        rd("stg_row0", 5'd0, 16'h10);
        rd("stg_row15", 5'd15, 16'h1F);
        wr(5'd16, 16'd5);
        rd("armed_status", 5'd19, 16'h1);
        copy(6'd5, 1'b0);
        chk("speed0_scroll", scroll_offset, 0);
        rd("idle_status", 5'd19, 16'h0);

        wr(5'd17, 16'd3);
        rd("speed_rd", 5'd17, 16'd3);
        wr(5'd18, 16'd1022);
        chk("direct_offset", scroll_offset, 1022);
        vb();
        chk("scroll_wrap", scroll_offset, 1);
        vb();
        chk("scroll_adv", scroll_offset, 4);

        stage(0, 8'h55);
        wr(5'd16, 16'd7);
        wr(5'd2, 16'hAA);
        wr(5'd16, 16'd9);
        rd("busy_status", 5'd19, 16'h7);
        rd("stg_protected", 5'd2, 16'h12);
        wr(5'd19, 16'h6);
        rd("w1c_status", 5'd19, 16'h1);
        copy(6'd7, 1'b1);
        chk("scroll_mid_copy", scroll_offset, 10);
        rd("post_copy_status", 5'd19, 16'h0);

        wr(5'd17, 16'd5);
        chipselect   = 1'b1;
        write        = 1'b1;
        address      = 5'd18;
        writedata    = 16'd100;
        vblank_start = 1'b1;
        tick();
        chk("offset_wins", scroll_offset, 100);
        address      = 5'd16;
        writedata    = 16'd3;
        tick();
        chipselect   = 1'b0;
        write        = 1'b0;
        vblank_start = 1'b0;
        chk("commit_vb_busy", busy, 1);
        repeat (5) tick();
        chk("commit_vb_scroll", scroll_offset, 105);
        copy(6'd3, 1'b0);
        chk("late_copy_scroll", scroll_offset, 110);

        wr(5'd16, 16'd12);
        push_col(6'd12);
        vb();
        repeat (7) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_we", tm_we, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_scroll", scroll_offset, 0);
        sb_q.delete();
        for (int r = 0; r < 16; r++) stg[r] = 8'h00;
        rd("async_rst_status", 5'd19, 16'h0);
        rd("async_rst_speed", 5'd17, 16'h0);
        rd("async_rst_stg", 5'd5, 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int r = 0; r < 16; r++) stage(r, 8'(8'hF0 - r));
        wr(5'd16, 16'd63);
        copy(6'd63, 1'b0);
        chk("final_scroll", scroll_offset, 0);
        tick();
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
